// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and types. The fetch queue, decoder and fetch
// unit all import this package, so the buffer geometry is defined in one place.
package fetch_pkg;

   localparam int FQ_DEPTH      = 128;  // circular buffer size in bytes
   localparam int FQ_WINDOW     = 15;   // longest x86 instruction
   localparam int FQ_WORD_BYTES = 8;    // bytes per fetch word
   localparam int FQ_PTR_W      = 7;    // byte pointer width, log2(FQ_DEPTH)
   localparam int FQ_CNT_W      = 8;    // occupancy width, holds 0..FQ_DEPTH

   // A whole word still fits while occupancy is at or below this level
   localparam int FQ_FILL_LIMIT = FQ_DEPTH - FQ_WORD_BYTES;

   typedef logic [FQ_PTR_W-1:0] fq_ptr_t;
   typedef logic [FQ_CNT_W-1:0] fq_cnt_t;

   // Bytes the decoder can see: occupancy capped at the window size
   function automatic logic [3:0] fq_window_count(input fq_cnt_t c);
      return (c >= fq_cnt_t'(FQ_WINDOW)) ? 4'(FQ_WINDOW) : c[3:0];
   endfunction

endpackage

// File: rtl/fq_window_rotate.sv
// Combinational extractor: returns FQ_WINDOW consecutive bytes of the circular
// buffer starting at the read pointer. The index wraps naturally because the
// pointer arithmetic is done at pointer width.
module fq_window_rotate
   import fetch_pkg::*;
(
   input  logic [FQ_DEPTH-1:0][7:0]  i_mem,
   input  fq_ptr_t                   i_rd,
   output logic [FQ_WINDOW*8-1:0]    o_window
);

   genvar gi;

   for (gi = 0; gi < FQ_WINDOW; gi++) begin : g_byte
      fq_ptr_t w_idx;
      assign w_idx                = i_rd + fq_ptr_t'(gi);
      assign o_window[gi*8 +: 8]  = i_mem[w_idx];
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: 128-byte circular byte buffer between the fetch
// unit (8-byte words) and the x86 decoder (15-byte sliding window). A flush
// redirects to a new address and drops the leading bytes of the next word so
// the window starts exactly at the target.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fill_valid,
   input  logic [63:0]              fill_data,
   output logic                     fill_ready,
   input  logic                     flush,
   input  logic [63:0]              flush_rip,
   output logic [FQ_WINDOW*8-1:0]   window_data,
   output logic [3:0]               window_avail,
   output logic                     window_valid,
   output logic [63:0]              window_rip,
   input  logic [3:0]               consume,
   output logic [7:0]               count
);

   logic [FQ_DEPTH-1:0][7:0]  r_mem;
   fq_ptr_t                   r_rd;
   fq_ptr_t                   r_wr;
   fq_cnt_t                   r_count;
   logic [2:0]                r_skip;
   logic [63:0]               r_rip;

   logic [3:0]                w_avail;
   logic                      w_fill_ready;
   logic                      w_accept;
   logic [3:0]                w_wr_bytes;
   logic [3:0]                w_eff;
   fq_cnt_t                   w_count_next;
   fq_ptr_t                   w_wr_idx [FQ_WORD_BYTES];
   logic                      w_wr_en  [FQ_WORD_BYTES];
   logic [FQ_WINDOW*8-1:0]    w_window;

   // Ready depends only on registered occupancy, so no input reaches it
   assign w_avail      = fq_window_count(r_count);
   assign w_fill_ready = (r_count <= fq_cnt_t'(FQ_FILL_LIMIT));
   assign w_accept     = fill_valid && w_fill_ready && !flush;
   assign w_wr_bytes   = w_accept ? (4'd8 - {1'b0, r_skip}) : 4'd0;
   // Over-consumption is clamped to what is visible; flush ignores consume
   assign w_eff        = flush ? 4'd0 : ((consume > w_avail) ? w_avail : consume);
   assign w_count_next = r_count + fq_cnt_t'(w_wr_bytes) - fq_cnt_t'(w_eff);

   // Byte lane gi of the word lands at wr + gi - skip; lanes below skip are dropped
   genvar gi;
   for (gi = 0; gi < FQ_WORD_BYTES; gi++) begin : g_wr
      assign w_wr_idx[gi] = r_wr + fq_ptr_t'(gi) - fq_ptr_t'(r_skip);
      assign w_wr_en[gi]  = w_accept && (3'(gi) >= r_skip);
   end

   // Buffer storage: contents are don't-care until counted, so no reset
   always_ff @(posedge clk) begin
      for (int j = 0; j < FQ_WORD_BYTES; j++) begin
         if (w_wr_en[j]) begin
            r_mem[w_wr_idx[j]] <= fill_data[8*j +: 8];
         end
      end
   end

   // Pointers, occupancy, skip and window address; flush beats fill and consume
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_skip  <= '0;
         r_rip   <= '0;
      end else if (flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_skip  <= flush_rip[2:0];
         r_rip   <= flush_rip;
      end else begin
         r_wr    <= r_wr + fq_ptr_t'(w_wr_bytes);
         r_rd    <= r_rd + fq_ptr_t'(w_eff);
         r_count <= w_count_next;
         r_rip   <= r_rip + 64'(w_eff);
         if (w_accept) begin
            r_skip <= '0;
         end
      end
   end

   // Decoder must never retire more bytes than the window shows
   always_ff @(posedge clk) begin
      if (reset && !flush) begin
         assert (consume <= w_avail);
      end
   end

   fq_window_rotate u_rotate (
      .i_mem    (r_mem),
      .i_rd     (r_rd),
      .o_window (w_window)
   );

   assign fill_ready   = w_fill_ready;
   assign window_data  = w_window;
   assign window_avail = w_avail;
   assign window_valid = (w_avail == 4'(FQ_WINDOW));
   assign window_rip   = r_rip;
   assign count        = r_count;

endmodule
